// File: rtl/program_sequencer.sv
// Runs programs 0, 1, 2 on an external core in order, timing each one and aborting it after TIMEOUT RUN cycles.
// result_cycles counts RUN cycles only: an ack seen N cycles after core_start reports N-2 (LAUNCH and SETTLE are not counted).
module program_sequencer #(
  parameter int unsigned PC_BITS = 10,
  parameter int unsigned START0  = 0,
  parameter int unsigned DONE0   = 145,
  parameter int unsigned START1  = 146,
  parameter int unsigned DONE1   = 290,
  parameter int unsigned START2  = 291,
  parameter int unsigned DONE2   = 435,
  parameter logic [15:0] TIMEOUT = 16'd4000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               go,
  input  logic               core_done,
  output logic               core_start,
  output logic [PC_BITS-1:0] start_addr,
  output logic [PC_BITS-1:0] done_addr,
  output logic [1:0]         prog_id,
  output logic               busy,
  output logic               result_valid,
  output logic [15:0]        result_cycles,
  output logic               result_timeout,
  output logic               all_done
);

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    SETTLE,
    RUN,
    RECORD,
    DONE
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  prog_id_q, prog_id_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] res_cycles_q, res_cycles_d;
  logic        res_to_q, res_to_d;

  always_comb begin
    state_d      = state_q;
    prog_id_d    = prog_id_q;
    cnt_d        = cnt_q;
    res_cycles_d = res_cycles_q;
    res_to_d     = res_to_q;
    case (state_q)
      IDLE: begin
        if (go) begin
          state_d   = LAUNCH;
          prog_id_d = 2'd0;
        end
      end
      LAUNCH: begin
        cnt_d   = 16'd0;
        state_d = SETTLE;
      end
      // core_done may still reflect the previous program here, so it is not looked at
      SETTLE: state_d = RUN;
      RUN: begin
        if (core_done) begin
          state_d      = RECORD;
          res_cycles_d = cnt_q;
          res_to_d     = 1'b0;
        end else if (cnt_q == TIMEOUT) begin
          state_d      = RECORD;
          res_cycles_d = cnt_q;
          res_to_d     = 1'b1;
        end else if (cnt_q != 16'hFFFF) begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      // an aborted program still advances the sequence
      RECORD: begin
        if (prog_id_q < 2'd2) begin
          prog_id_d = prog_id_q + 2'd1;
          state_d   = LAUNCH;
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (!go) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      prog_id_q    <= 2'd0;
      cnt_q        <= 16'd0;
      res_cycles_q <= 16'd0;
      res_to_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      prog_id_q    <= prog_id_d;
      cnt_q        <= cnt_d;
      res_cycles_q <= res_cycles_d;
      res_to_q     <= res_to_d;
    end
  end

  always_comb begin
    case (prog_id_q)
      2'd1: begin
        start_addr = PC_BITS'(START1);
        done_addr  = PC_BITS'(DONE1);
      end
      2'd2: begin
        start_addr = PC_BITS'(START2);
        done_addr  = PC_BITS'(DONE2);
      end
      default: begin
        start_addr = PC_BITS'(START0);
        done_addr  = PC_BITS'(DONE0);
      end
    endcase
  end

  assign core_start     = (state_q == LAUNCH);
  assign busy           = (state_q != IDLE);
  assign result_valid   = (state_q == RECORD);
  assign all_done       = (state_q == DONE);
  assign prog_id        = prog_id_q;
  assign result_cycles  = res_cycles_q;
  assign result_timeout = res_to_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Bench for program_sequencer: table of per-program ack delays with expected results, a core model and a result scoreboard.
module tb_program_sequencer;
  localparam int PC_BITS = 10;
  localparam logic [15:0] TO = 16'd50;

  logic               clock = 1'b0;
  logic               reset, go, core_done;
  logic               core_start, busy, result_valid, result_timeout, all_done;
  logic [PC_BITS-1:0] start_addr, done_addr;
  logic [1:0]         prog_id;
  logic [15:0]        result_cycles;

  always #5 clock = ~clock;

  program_sequencer #(.PC_BITS(PC_BITS), .TIMEOUT(TO)) u_dut (
    .clock(clock), .reset(reset), .go(go), .core_done(core_done),
    .core_start(core_start), .start_addr(start_addr), .done_addr(done_addr),
    .prog_id(prog_id), .busy(busy), .result_valid(result_valid),
    .result_cycles(result_cycles), .result_timeout(result_timeout),
    .all_done(all_done)
  );

  typedef struct {
    int cyc;
    bit to;
  } exp_t;

  // delays are cycles from the core_start cycle to the first cycle core_done is high (-1: never)
  typedef struct {
    int d0, d1, d2;
    int c0, c1, c2;
    bit t0, t1, t2;
    bit st;
  } vec_t;

  exp_t sb[$];
  int   errors = 0, checks = 0;
  int   dly[3], exp_cyc[3];
  bit   exp_to[3];
  bit   stale = 0;
  int   exp_idx = 0, t = 0, cur_dly = -1, n_starts = 0;
  bit   armed = 0, prev_cs = 0;
  int   start_tab[3] = '{0, 146, 291};
  int   done_tab[3]  = '{145, 290, 435};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // runs on the falling edge: checks launches and results, then drives core_done for the coming rising edge
  task automatic monitor();
    exp_t e;
    if (reset) begin
      sb.delete();
      exp_idx = 0;
      armed   = 0;
      prev_cs = 0;
    end else begin
      if (core_start) begin
        check("core_start_single", prev_cs, 0);
        check("launch_prog_id", prog_id, exp_idx);
        check("launch_start_addr", start_addr, start_tab[exp_idx]);
        check("launch_done_addr", done_addr, done_tab[exp_idx]);
        e.cyc = exp_cyc[exp_idx];
        e.to  = exp_to[exp_idx];
        sb.push_back(e);
        cur_dly = dly[exp_idx];
        exp_idx = (exp_idx + 1) % 3;
        n_starts++;
        t     = 0;
        armed = 1;
      end else if (armed) begin
        t++;
      end
      if (result_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got result_valid, expected none");
        end else begin
          e = sb.pop_front();
          check("result_cycles", result_cycles, e.cyc);
          check("result_timeout", result_timeout, e.to);
        end
      end
      prev_cs = core_start;
    end
    core_done = stale | (armed && cur_dly >= 0 && t >= cur_dly);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input vec_t v);
    dly[0] = v.d0; dly[1] = v.d1; dly[2] = v.d2;
    exp_cyc[0] = v.c0; exp_cyc[1] = v.c1; exp_cyc[2] = v.c2;
    exp_to[0] = v.t0; exp_to[1] = v.t1; exp_to[2] = v.t2;
    stale = v.st;
  endtask

  task automatic wait_all_done(input int max_cycles);
    int n = 0;
    while (all_done !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    check("all_done_reached", all_done, 1);
  endtask

  // finish a sequence, hold go to confirm no retrigger, then drop go for exactly one cycle
  task automatic finish_seq(input int starts_before);
    wait_all_done(600);
    check("sb_drained", sb.size(), 0);
    check("three_launches", n_starts - starts_before, 3);
    repeat (5) tick();
    check("done_hold_all_done", all_done, 1);
    check("no_retrigger", n_starts - starts_before, 3);
    go = 0;
    tick();
    check("idle_busy", busy, 0);
    check("idle_all_done", all_done, 0);
  endtask

  initial begin
    vec_t vecs[5];
    int   s0, n;
    reset = 1; go = 0; core_done = 0;
    fork
      forever begin
        @(negedge clock);
        monitor();
      end
    join_none

    vecs[0] = '{d0:10, d1:20, d2:30, c0:8,  c1:18, c2:28, t0:0, t1:0, t2:0, st:0};
    vecs[1] = '{d0:10, d1:-1, d2:15, c0:8,  c1:50, c2:13, t0:0, t1:1, t2:0, st:0};
    vecs[2] = '{d0:52, d1:53, d2:5,  c0:50, c1:50, c2:3,  t0:0, t1:1, t2:0, st:0};
    vecs[3] = '{d0:4,  d1:4,  d2:4,  c0:0,  c1:0,  c2:0,  t0:0, t1:0, t2:0, st:1};
    vecs[4] = '{d0:1,  d1:2,  d2:3,  c0:0,  c1:0,  c2:1,  t0:0, t1:0, t2:0, st:0};

    repeat (2) tick();
    check("rst_busy", busy, 0);
    check("rst_core_start", core_start, 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_result_cycles", result_cycles, 0);
    check("rst_result_timeout", result_timeout, 0);
    check("rst_all_done", all_done, 0);
    check("rst_prog_id", prog_id, 0);
    check("rst_start_addr", start_addr, 0);
    check("rst_done_addr", done_addr, 145);
    reset = 0;
    tick();

    for (int i = 0; i < 5; i++) begin
      load(vecs[i]);
      s0 = n_starts;
      go = 1;
      finish_seq(s0);
    end
    stale = 0;

    // reset during RUN cycle 7 of program 1 (cycle 9 after its core_start)
    load(vecs[0]);
    go = 1;
    n = 0;
    while (!(core_start === 1'b1 && prog_id === 2'd1) && n < 200) begin
      tick();
      n++;
    end
    check("prog1_launch_seen", core_start, 1);
    repeat (9) tick();
    check("mid_run_busy", busy, 1);
    check("mid_run_no_result", result_valid, 0);
    reset = 1;
    tick();
    check("mid_rst_busy", busy, 0);
    check("mid_rst_prog_id", prog_id, 0);
    check("mid_rst_result_valid", result_valid, 0);
    check("mid_rst_result_cycles", result_cycles, 0);
    check("mid_rst_start_addr", start_addr, 0);
    check("mid_rst_all_done", all_done, 0);
    reset = 0;
    s0 = n_starts;
    finish_seq(s0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Parameters
REQ-001 SHALL have parameter PC_BITS, default 10, program-counter address width.
REQ-002 SHALL have parameters START0/DONE0, START1/DONE1, START2/DONE2, defaults 0/145, 146/290, 291/435, start and done addresses of programs 0..2.
REQ-003 SHALL have parameter TIMEOUT, default 16'd4000, maximum RUN cycles per program before abort.

Interface
REQ-004 clock  in  1  system clock; all state changes on rising edge.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 go  in  1  level request to run programs 0,1,2 in order; sampled only in IDLE.
REQ-007 core_done  in  1  core ack; high while the core PC sits at its done address.
REQ-008 core_start  out  1  core req; one-cycle pulse that loads the core PC with start_addr.
REQ-009 start_addr  out  PC_BITS  starting address for the current program.
REQ-010 done_addr  out  PC_BITS  done address for the current program.
REQ-011 prog_id  out  2  index of the current program, 0..2.
REQ-012 busy  out  1  high in every state except IDLE.
REQ-013 result_valid  out  1  one-cycle pulse when a program finishes or aborts.
REQ-014 result_cycles  out  16  RUN-cycle count of the program just finished; held until the next result_valid.
REQ-015 result_timeout  out  1  set with result_valid when the program aborted; held like result_cycles.
REQ-016 all_done  out  1  high from completion of program 2 until go is low in DONE.

Function
REQ-017 FSM states SHALL be IDLE, LAUNCH, SETTLE, RUN, RECORD, DONE.
REQ-018 IDLE & go=1 -> LAUNCH, prog_id<=0; otherwise stay in IDLE.
REQ-019 LAUNCH SHALL assert core_start for exactly one cycle, clear cycle counter, then -> SETTLE.
REQ-020 SETTLE SHALL last one cycle and ignore core_done (stale ack from the previous program), then -> RUN.
REQ-021 RUN SHALL increment a 16-bit counter each cycle, saturating at 16'hFFFF, never wrapping.
REQ-022 RUN & core_done=1 -> RECORD with timeout flag 0; the counter does not increment in that cycle.
REQ-023 RUN & counter==TIMEOUT & core_done=0 -> RECORD with timeout flag 1.
REQ-024 If core_done=1 and counter==TIMEOUT in the same cycle, completion SHALL win (timeout flag 0).
REQ-025 RECORD SHALL pulse result_valid, latch result_cycles/result_timeout, then -> LAUNCH with prog_id+1 if prog_id<2, else -> DONE.
REQ-026 An abort SHALL NOT stop the sequence; the next program still launches.
REQ-027 DONE SHALL assert all_done and -> IDLE when go=0; go held high SHALL NOT retrigger.
REQ-028 start_addr/done_addr SHALL be a registered or combinational decode of prog_id, valid whenever core_start is high.
REQ-029 go changes outside IDLE and DONE SHALL be ignored.
REQ-030 core_start SHALL never be high in two consecutive cycles.

Reset
REQ-031 reset=1 SHALL, on the next edge, force IDLE, prog_id=0, core_start=0, busy=0, result_valid=0, result_cycles=0, result_timeout=0, all_done=0, counter=0.
REQ-032 reset SHALL take priority over every transition, including mid-RUN; no result_valid SHALL be produced for the interrupted program.
REQ-033 start_addr=START0 and done_addr=DONE0 SHALL hold after reset.

Verification
REQ-034 Nominal run: go=1; core model raises core_done 10, 20, 30 cycles after each core_start -> three result_valid pulses with result_cycles 10, 20, 30 (+/- SETTLE offset, fixed and documented); timeout=0; all_done=1.
REQ-035 Timeout: TIMEOUT=50, core never acks program 1 -> result_timeout=1 and result_cycles=50 for prog 1; program 2 still launches with start_addr=291.
REQ-036 Stale ack: core_done held high through LAUNCH/SETTLE -> no early completion; first counted RUN cycle completes with result_cycles=0 or 1 per design (documented).
REQ-037 Tie: core_done rises exactly when counter==TIMEOUT -> result_timeout=0.
REQ-038 Reset at RUN cycle 7 of program 1 -> next cycle IDLE, busy=0, no result_valid; go=1 then restarts at prog_id=0.
REQ-039 go held high after DONE -> no second sequence; go low for 1 cycle then high -> new sequence starts from program 0.
